// File: rtl/pwm_drive_pkg.sv
// Shared definitions for the half-bridge dead-time driver.
//   - drive_state_e : one-hot FSM state encoding (one bit per state, so each
//                     gate output is a single flop bit)
//   - DEAD_CYCLES_DEFAULT / CNT_W_DEFAULT : default dead time and counter width
//   - dead_cnt_width() : smallest counter width able to hold DEAD_CYCLES-1
package pwm_drive_pkg;

  localparam int DEAD_CYCLES_DEFAULT = 4;
  localparam int CNT_W_DEFAULT       = 8;

  typedef enum logic [5:0] {
    IDLE  = 6'b000001,
    DT_LS = 6'b000010,
    LS_ON = 6'b000100,
    DT_HS = 6'b001000,
    HS_ON = 6'b010000,
    FAULT = 6'b100000
  } drive_state_e;

  // Width needed for a counter that is loaded with dead_cycles-1.
  function automatic int dead_cnt_width(input int dead_cycles);
    int w;
    w = 1;
    while ((1 << w) <= (dead_cycles - 1)) w++;
    return w;
  endfunction

endpackage

// File: rtl/pwm_deadtime_driver_if.sv
// Bundle of the PWM input, control/fault inputs and gate-drive outputs of one
// half-bridge leg.
//   master : the controlling side (PWM generator / board logic)
//   slave  : the dead-time driver itself
// Signals:
//   Pulse_In      PWM bit from the sine generator
//   Enable        bridge enable, low forces both drives off
//   Fault_N       external fault, active low
//   Fault_Clr     single-cycle clear of a latched fault
//   HS_Drive      high-side gate drive, active high
//   LS_Drive      low-side gate drive, active high
//   Fault_Latched high while the driver sits in FAULT
//   Drive_Active  high while either gate is driven
interface pwm_deadtime_driver_if;

  logic Pulse_In;
  logic Enable;
  logic Fault_N;
  logic Fault_Clr;
  logic HS_Drive;
  logic LS_Drive;
  logic Fault_Latched;
  logic Drive_Active;

  modport master (
    output Pulse_In, Enable, Fault_N, Fault_Clr,
    input  HS_Drive, LS_Drive, Fault_Latched, Drive_Active
  );

  modport slave (
    input  Pulse_In, Enable, Fault_N, Fault_Clr,
    output HS_Drive, LS_Drive, Fault_Latched, Drive_Active
  );

endinterface

// File: rtl/pwm_deadtime_driver_deadtime_timer.sv
// Down-counter that times one dead interval.
//   clk        system clock
//   rst_n      synchronous reset, active low
//   load_i     load cnt_init_i (asserted on the edge that enters a dead state)
//   run_i      high while the FSM sits in a dead state
//   cnt_init_i value loaded on entry (DEAD_CYCLES-1)
//   done_o     high when the count has reached zero inside a dead state
module deadtime_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic             run_i,
  input  logic [CNT_W-1:0] cnt_init_i,
  output logic             done_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Load wins over counting; the count parks at zero so done stays valid
  // for as long as the FSM lingers.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = cnt_init_i;
    end else if (run_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = run_i && (cnt_q == '0);

endmodule

// File: rtl/pwm_deadtime_driver.sv
// Complementary gate-drive generator for one half-bridge leg.
// Turns the single-ended PWM bit into HS/LS drives with a fixed dead time
// (both low) on every transition, swallows pulses shorter than the dead time
// and forces a safe off state on enable removal or an external fault.
//   sysclk  system clock, rising edge
//   rst_n   synchronous reset, active low
//   drv     pwm_deadtime_driver_if slave: PWM/control inputs, gate outputs
// Parameters:
//   DEAD_CYCLES  cycles with both drives low per transition (1..255)
//   CNT_W        dead-time counter width, 2**CNT_W > DEAD_CYCLES
module pwm_deadtime_driver
  import pwm_drive_pkg::*;
#(
  parameter int DEAD_CYCLES = DEAD_CYCLES_DEFAULT,
  parameter int CNT_W       = CNT_W_DEFAULT
) (
  input  logic                  sysclk,
  input  logic                  rst_n,
  pwm_deadtime_driver_if.slave  drv
);

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(DEAD_CYCLES - 1);

  drive_state_e state_q, state_d;
  logic         pulse_q;
  logic         dead_run;
  logic         timer_load;
  logic         timer_done;

  assign dead_run = (state_q == DT_LS) || (state_q == DT_HS);

  // Next-state logic. Fault beats everything, then enable; once a dead
  // interval starts it runs to completion and only then looks at pulse_q.
  // A pulse that has already ended when DT_HS expires goes straight back to
  // LS_ON without a second dead time, because HS never conducted.
  always_comb begin
    state_d = state_q;
    if (!drv.Fault_N) begin
      state_d = FAULT;
    end else if (!drv.Enable && (state_q != FAULT)) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    state_d = DT_LS;
        DT_LS:   if (timer_done) state_d = LS_ON;
        LS_ON:   if (pulse_q) state_d = DT_HS;
        DT_HS:   if (timer_done) state_d = pulse_q ? HS_ON : LS_ON;
        HS_ON:   if (!pulse_q) state_d = DT_LS;
        FAULT:   if (drv.Fault_Clr) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // The timer is reloaded on the edge that enters a dead state so the first
  // dead cycle already sees DEAD_CYCLES-1.
  assign timer_load = (state_d != state_q) &&
                      ((state_d == DT_LS) || (state_d == DT_HS));

  deadtime_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk        (sysclk),
    .rst_n      (rst_n),
    .load_i     (timer_load),
    .run_i      (dead_run),
    .cnt_init_i (CNT_INIT),
    .done_o     (timer_done)
  );

  // State register and the one-cycle input register on the PWM bit.
  always_ff @(posedge sysclk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pulse_q <= drv.Pulse_In;
    end
  end

  // Outputs decode the one-hot state register directly, so they are glitch
  // free and HS/LS can never be high together.
  assign drv.HS_Drive      = (state_q == HS_ON);
  assign drv.LS_Drive      = (state_q == LS_ON);
  assign drv.Fault_Latched = (state_q == FAULT);
  assign drv.Drive_Active  = (state_q == HS_ON) || (state_q == LS_ON);

endmodule

// File: tb/tb_pwm_deadtime_driver.sv
// Self-checking bench for pwm_deadtime_driver. An independent behavioural
// model predicts the pins {HS,LS,Fault_Latched,Drive_Active} for every clock;
// the prediction is queued when stimulus is driven and popped once the DUT
// has clocked. Directed phases also check the documented timeline with
// constants, and every cycle checks HS/LS overlap and dead-gap width.
module tb_pwm_deadtime_driver;

  localparam int DEAD    = 4;
  localparam int CARRIER = 16;

  typedef enum int {M_IDLE, M_DTLS, M_LS, M_DTHS, M_HS, M_FAULT} mstate_t;

  logic sysclk;
  logic rstN;
  logic [3:0] pins;
  logic [3:0] expQ[$];

  int checkCount;
  int passCount;
  int cycleCount;
  int lastFall;
  bit fallSeen;
  logic prevHs;
  logic prevLs;

  mstate_t mState;
  int      deadLeft;
  logic    mPulse;

  int sineDuty[64];

  pwm_deadtime_driver_if drvIf ();

  pwm_deadtime_driver #(
    .DEAD_CYCLES (DEAD),
    .CNT_W       (8)
  ) dut (
    .sysclk (sysclk),
    .rst_n  (rstN),
    .drv    (drvIf)
  );

  assign pins = {drvIf.HS_Drive, drvIf.LS_Drive, drvIf.Fault_Latched, drvIf.Drive_Active};

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s cycle %0d: got %0h, expected %0h", tag, cycleCount, observed, expected);
    end
  endtask

  task automatic expectPins(input string tag, input logic [3:0] exp);
    checkOutput(tag, {28'd0, pins}, {28'd0, exp});
  endtask

  // Reference model: deadLeft counts dead cycles still to be spent,
  // including the current one.
  task automatic modelStep(input logic p, input logic en, input logic fn, input logic clr, input logic rst);
    mstate_t nxt;
    if (!rst) begin
      mState   = M_IDLE;
      mPulse   = 1'b0;
      deadLeft = 0;
    end else begin
      nxt = mState;
      if (!fn) nxt = M_FAULT;
      else if (!en && mState != M_FAULT) nxt = M_IDLE;
      else begin
        case (mState)
          M_IDLE:  nxt = M_DTLS;
          M_DTLS:  if (deadLeft == 1) nxt = M_LS; else deadLeft--;
          M_LS:    if (mPulse) nxt = M_DTHS;
          M_DTHS:  if (deadLeft == 1) nxt = mPulse ? M_HS : M_LS; else deadLeft--;
          M_HS:    if (!mPulse) nxt = M_DTLS;
          M_FAULT: if (clr) nxt = M_IDLE;
          default: nxt = M_IDLE;
        endcase
      end
      if ((nxt == M_DTLS || nxt == M_DTHS) && nxt != mState) deadLeft = DEAD;
      mState = nxt;
      mPulse = p;
    end
  endtask

  function automatic logic [3:0] modelPins();
    logic hs, ls;
    hs = (mState == M_HS);
    ls = (mState == M_LS);
    return {hs, ls, mState == M_FAULT, hs | ls};
  endfunction

  task automatic applyStimulus(input logic p, input logic en, input logic fn, input logic clr, input logic rst);
    logic [3:0] exp;
    int gap;
    @(negedge sysclk);
    drvIf.Pulse_In  = p;
    drvIf.Enable    = en;
    drvIf.Fault_N   = fn;
    drvIf.Fault_Clr = clr;
    rstN            = rst;
    modelStep(p, en, fn, clr, rst);
    expQ.push_back(modelPins());
    @(posedge sysclk);
    #1;
    cycleCount++;
    exp = expQ.pop_front();
    expectPins("scoreboard", exp);
    checkOutput("overlap", {31'd0, pins[3] & pins[2]}, 32'd0);
    if ((prevHs && !pins[3]) || (prevLs && !pins[2])) begin
      lastFall = cycleCount;
      fallSeen = 1'b1;
    end
    if (fallSeen && ((!prevHs && pins[3]) || (!prevLs && pins[2]))) begin
      gap = cycleCount - lastFall;
      checkOutput("deadGapAtLeastDead", {31'd0, gap >= DEAD}, 32'd1);
    end
    prevHs = pins[3];
    prevLs = pins[2];
  endtask

  initial begin
    checkCount = 0;
    passCount  = 0;
    cycleCount = 0;
    lastFall   = 0;
    fallSeen   = 1'b0;
    prevHs     = 1'b0;
    prevLs     = 1'b0;
    mState     = M_IDLE;
    mPulse     = 1'b0;
    deadLeft   = 0;
    rstN            = 1'b0;
    drvIf.Pulse_In  = 1'b0;
    drvIf.Enable    = 1'b0;
    drvIf.Fault_N   = 1'b1;
    drvIf.Fault_Clr = 1'b0;
    for (int k = 0; k < 64; k++)
      sineDuty[k] = int'(8.0 + 8.0 * $sin(2.0 * 3.14159265358979 * real'(k) / 64.0));

    // Reset state
    applyStimulus(0, 0, 1, 0, 0);
    applyStimulus(0, 0, 1, 0, 0);
    expectPins("reset", 4'b0000);

    // Enable: full dead interval before LS comes on
    for (int i = 0; i < 10; i++) begin
      applyStimulus(0, 1, 1, 0, 1);
      expectPins("bootLs", (i >= DEAD) ? 4'b0101 : 4'b0000);
    end

    // Zero duty stays in LS_ON
    for (int i = 0; i < 8; i++) begin
      applyStimulus(0, 1, 1, 0, 1);
      expectPins("zeroDuty", 4'b0101);
    end

    // Long pulse: LS falls after edge 1, HS rises after edge 5
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1, 1, 1, 0, 1);
      expectPins("riseToHs", (i == 0) ? 4'b0101 : (i >= 5) ? 4'b1001 : 4'b0000);
    end
    for (int i = 0; i < 12; i++) begin
      applyStimulus(0, 1, 1, 0, 1);
      expectPins("fallToLs", (i == 0) ? 4'b1001 : (i >= 5) ? 4'b0101 : 4'b0000);
    end

    // Short pulse is swallowed, HS never asserts
    for (int i = 0; i < 10; i++) begin
      applyStimulus(logic'(i < 2), 1, 1, 0, 1);
      expectPins("swallow", (i == 0 || i >= 5) ? 4'b0101 : 4'b0000);
    end

    // Fault while HS_ON
    for (int i = 0; i < 8; i++) applyStimulus(1, 1, 1, 0, 1);
    expectPins("hsBeforeFault", 4'b1001);
    applyStimulus(1, 1, 0, 0, 1);
    expectPins("faultEntry", 4'b0010);
    applyStimulus(1, 1, 0, 1, 1);
    expectPins("clrIgnored", 4'b0010);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 1, 1, 0, 1);
      expectPins("faultHold", 4'b0010);
    end
    applyStimulus(0, 1, 1, 1, 1);
    expectPins("faultClr", 4'b0000);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(0, 1, 1, 0, 1);
      expectPins("postFault", (i >= DEAD) ? 4'b0101 : 4'b0000);
    end

    // Enable removed during DT_HS
    applyStimulus(1, 1, 1, 0, 1);
    applyStimulus(1, 1, 1, 0, 1);
    expectPins("inDtHs", 4'b0000);
    applyStimulus(1, 0, 1, 0, 1);
    expectPins("enDrop", 4'b0000);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(0, 1, 1, 0, 1);
      expectPins("reEnable", (i >= DEAD) ? 4'b0101 : 4'b0000);
    end

    // Sine duty sweep, three periods, reset pulsed mid-sweep
    for (int per = 0; per < 3; per++) begin
      for (int s = 0; s < 64; s++) begin
        for (int ph = 0; ph < CARRIER; ph++) begin
          if (per == 1 && s == 32 && ph == 0) begin
            applyStimulus(1, 1, 1, 0, 0);
            expectPins("sweepReset", 4'b0000);
          end else begin
            applyStimulus(logic'(ph < sineDuty[s]), 1, 1, 0, 1);
          end
        end
      end
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/pwm_deadtime_driver.md
Name: pwm_deadtime_driver

Overview:
- Downstream consumer of the sine-PWM Pulse stream.
- Converts the single-ended PWM bit into complementary high-side/low-side gate drives for one half-bridge leg.
- Guarantees a programmable dead time with both drives low on every transition, swallows pulses shorter than the dead time, and forces a safe off state on enable removal or external fault.
- Sits between the PWM generator and the FPGA output pins that drive the gate driver IC.

Parameters:
- DEAD_CYCLES, 4, sysclk cycles with both drives low on each transition; legal range 1..255.
- CNT_W, 8, dead-time counter width; must satisfy 2**CNT_W > DEAD_CYCLES.

Ports:
- sysclk  input  1  system clock; all logic on its rising edge.
- rst_n  input  1  synchronous reset, active low.
- Pulse_In  input  1  PWM bit from the sine generator, same clock domain.
- Enable  input  1  bridge enable; low forces both drives off.
- Fault_N  input  1  external fault, active low, same clock domain.
- Fault_Clr  input  1  single-cycle pulse that clears a latched fault.
- HS_Drive  output  1  high-side gate drive, active high.
- LS_Drive  output  1  low-side gate drive, active high.
- Fault_Latched  output  1  high while in FAULT.
- Drive_Active  output  1  high in HS_ON or LS_ON.

Behaviour:
- One clock domain (sysclk). Reset is synchronous and active-low on rst_n.
- Reset (rst_n=0 at an edge):
  - state=IDLE, pulse_q=0, cnt=0.
  - All outputs 0.
- pulse_q: Pulse_In registered once, giving one cycle of input latency.
- Outputs are a combinational decode of the state register only:
  - HS_Drive=1 only in HS_ON.
  - LS_Drive=1 only in LS_ON.
  - HS_Drive and LS_Drive are never both 1 in any state.
- States: IDLE, DT_LS, LS_ON, DT_HS, HS_ON, FAULT.
- Dead-time states (DT_HS, DT_LS):
  - Entered with cnt=DEAD_CYCLES-1.
  - Decrement each cycle; leave on the cycle cnt==0.
  - Each dead interval is exactly DEAD_CYCLES cycles with both drives low.
- Transitions, in priority order, evaluated every edge:
  1. Fault_N=0 in any state -> FAULT.
  2. Enable=0 in any non-FAULT state -> IDLE.
  3. IDLE & Enable=1 -> DT_LS. Low side on first, for bootstrap charge.
  4. DT_LS & cnt==0 -> LS_ON.
  5. LS_ON & pulse_q=1 -> DT_HS.
  6. DT_HS & cnt==0:
     - pulse_q=1 -> HS_ON.
     - pulse_q=0 -> LS_ON. The pulse is swallowed; no second dead time, since HS never turned on.
  7. HS_ON & pulse_q=0 -> DT_LS.
  8. FAULT & Fault_Clr=1 & Fault_N=1 -> IDLE.
     - Fault_Clr while Fault_N=0 is ignored.
     - FAULT persists indefinitely otherwise.
- Timing, DEAD_CYCLES=4, starting in LS_ON:
  - Pulse_In high before edge 0 -> pulse_q=1 after edge 0.
  - LS_Drive falls after edge 1.
  - HS_Drive rises after edge 5.
  - The falling Pulse_In path is symmetric.
- pulse_q changes during a dead interval are ignored until cnt==0; no restart, no early exit.
- Fault path: Fault_N sampled 0 at edge k -> both drives 0 and Fault_Latched=1 after edge k, from any state including mid-dead-time.
- Reset mid-operation: immediate return to IDLE regardless of state or counter value; all outputs 0 after that edge.
- Zero-duty stream (Pulse_In always 0) -> remains in LS_ON.

Decomposition:
- Shared package pwm_drive_pkg holds:
  - state enumeration, localparam encodings, one-hot recommended;
  - default DEAD_CYCLES constant;
  - counter width helper.
- One sub-module is natural: deadtime_timer.
  - Inputs: load, cnt_init.
  - Output: done, asserted when cnt==0 in a dead state.
  - The FSM stays in pwm_deadtime_driver.

Test Plan:
- Reset then Enable=1, Pulse_In=0, DEAD_CYCLES=4 -> both drives 0 for 4 cycles after leaving IDLE, then LS_Drive=1 steady.
- From LS_ON, Pulse_In high for 20 cycles -> LS falls 2 edges after Pulse_In, 4 both-low cycles, HS high; then symmetric return to LS with 4 dead cycles.
- From LS_ON, Pulse_In high for 2 cycles -> HS_Drive never asserts; LS returns after the 4-cycle dead interval.
- Fault_N low for 1 cycle while HS_ON -> both drives 0 and Fault_Latched=1 after that edge.
  - Fault_Clr while Fault_N=0 has no effect.
  - Fault_Clr with Fault_N=1 -> IDLE, then DT_LS.
- Enable low during DT_HS -> IDLE next edge with all outputs 0; Enable high again -> a full 4-cycle DT_LS before LS_ON.
- Drive the full 64-step sine duty sweep for 3 periods with assertions:
  - HS&LS never both 1.
  - Every HS/LS edge pair is separated by at least DEAD_CYCLES cycles.
  - rst_n low mid-sweep -> all outputs 0 next edge.
